// File: rtl/cmp_mem_pkg.sv
// Shared definitions for the dmem sharing logic: dmem geometry and requester port ids.
package cmp_mem_pkg;

   localparam int unsigned DMEM_ADDR_W = 8;
   localparam int unsigned DMEM_DATA_W = 64;

   // Port 0 is the processor load/store path, port 1 the NIC-side DMA engine.
   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_NIC = 1'b1
   } port_id_e;

   function automatic port_id_e other_port(input port_id_e p);
      return (p == PORT_CPU) ? PORT_NIC : PORT_CPU;
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_2.sv
// Two-way round-robin arbiter with a bounded burst: the current owner keeps
// winning ties until it has taken MAX_BURST consecutive grants.
module rr_burst_arbiter_2
   import cmp_mem_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   localparam int unsigned       CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

   port_id_e         last_owner;
   logic [CNT_W-1:0] burst_cnt;
   port_id_e         win;

   // Pick the winner for this cycle; grants are suppressed entirely while in reset.
   // With no burst in progress (burst_cnt==0, as after reset or an idle cycle)
   // port 0 wins a tie; the reset state is identical to the post-idle state.
   always_comb begin
      win  = PORT_CPU;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0 && req1) begin
            if (burst_cnt == '0)
               win = PORT_CPU;
            else if (burst_cnt < CNT_MAX)
               win = last_owner;
            else
               win = other_port(last_owner);
         end else if (req1) begin
            win = PORT_NIC;
         end
         gnt0 = req0 && (win == PORT_CPU);
         gnt1 = req1 && (win == PORT_NIC);
      end
   end

   // Track the owner of the current run of grants and its length.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner <= PORT_NIC;
         burst_cnt  <= '0;
      end else if (gnt0 || gnt1) begin
         if (win == last_owner) begin
            if (burst_cnt != CNT_MAX)
               burst_cnt <= burst_cnt + 1'b1;
         end else begin
            last_owner <= win;
            burst_cnt  <= CNT_W'(1);
         end
      end else begin
         burst_cnt <= '0;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares single-port dmem between the processor (port 0) and the NIC DMA (port 1).
// One access is issued per cycle; load data returns one cycle after the grant.
module dmem_port_arbiter
   import cmp_mem_pkg::*;
#(
   parameter int unsigned ADDR_W    = DMEM_ADDR_W,
   parameter int unsigned DATA_W    = DMEM_DATA_W,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   rr_burst_arbiter_2 #(
      .MAX_BURST (MAX_BURST)
   ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .req1  (req1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   // Route the granted port's request onto the dmem interface; idle drives zeros.
   always_comb begin
      mem_en    = 1'b0;
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      if (gnt0) begin
         mem_en    = 1'b1;
         mem_wr_en = we0;
         mem_addr  = addr0;
         mem_din   = wdata0;
      end else if (gnt1) begin
         mem_en    = 1'b1;
         mem_wr_en = we1;
         mem_addr  = addr1;
         mem_din   = wdata1;
      end
   end

   // Flag load data as valid the cycle after a load grant, matching dmem read latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
      end
   end

   // Only the port that owns the returning load sees dmem data.
   always_comb begin
      rdata0 = rvalid0 ? mem_dout : '0;
      rdata1 = rvalid1 ? mem_dout : '0;
   end

endmodule
